uart_vram_reader: RTL

UART_VRAM_READER -- requirements
Module: uart_vram_reader

---
 rtl/uart_vram_pkg.sv | 20 ++
 rtl/uart_vram_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_vram_pkg.sv
// Shared definitions for the VRAM-to-UART dump engine: FSM states, byte order,
// and the supported read-latency ceiling.
package uart_vram_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    SEND_LO  = 3'd3,
    SEND_HI  = 3'd4,
    SEND_SUM = 3'd5,
    FIN      = 3'd6
  } state_t;

  // 1: each 16-bit word goes out low byte first.
  localparam logic BYTE_LO_FIRST = 1'b1;

  localparam int RAM_LAT_MAX = 3;

endpackage

// File: rtl/uart_vram_reader.sv
// Streams a range of 16-bit VRAM words to a byte-wide UART transmitter.
// Define UART_VRAM_READER_CHECKSUM_EN to append an XOR checksum byte after the data.
module uart_vram_reader
  import uart_vram_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic        I_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_cnt,
  input  logic        abort,
  output logic [15:0] ram_addr,
  output logic        ram_re,
  input  logic [15:0] ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        busy,
  output logic        done
);

  if (RAM_LAT < 1 || RAM_LAT > RAM_LAT_MAX) begin : g_bad_lat
    $error("uart_vram_reader: RAM_LAT out of range");
  end

`ifdef UART_VRAM_READER_CHECKSUM_EN
  localparam state_t LAST_ST = SEND_SUM;
  logic [7:0] sum_q, sum_d;
`else
  localparam state_t LAST_ST = FIN;
`endif

  state_t             state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        word_q, word_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               abort_q, abort_d;
  logic [RAM_LAT-1:0] lat_q, lat_d;
  logic               stop;

  // An abort pulse is remembered so a stalled byte can still complete first.
  assign stop = abort | abort_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    tx_data_d = tx_data_q;
    lat_d     = '0;
    abort_d   = abort_q | (abort && state_q != IDLE);
`ifdef UART_VRAM_READER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_cnt;
          state_d = RD_REQ;
`ifdef UART_VRAM_READER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      RD_REQ: begin
        lat_d   = RAM_LAT'(1);
        state_d = stop ? LAST_ST : RD_WAIT;
      end
      RD_WAIT: begin
        lat_d = lat_q << 1;
        if (stop) begin
          state_d = LAST_ST;
        end else if (lat_q[RAM_LAT-1]) begin
          word_d    = ram_rdata;
          tx_data_d = BYTE_LO_FIRST ? ram_rdata[7:0] : ram_rdata[15:8];
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_data_ready) begin
`ifdef UART_VRAM_READER_CHECKSUM_EN
          sum_d = sum_q ^ tx_data_q;
`endif
          tx_data_d = BYTE_LO_FIRST ? word_q[15:8] : word_q[7:0];
          state_d   = stop ? LAST_ST : SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_data_ready) begin
`ifdef UART_VRAM_READER_CHECKSUM_EN
          sum_d = sum_q ^ tx_data_q;
`endif
          addr_d = addr_q + 16'd1;
          if (stop || cnt_q == 16'd0) begin
            state_d = LAST_ST;
          end else begin
            cnt_d   = cnt_q - 16'd1;
            state_d = RD_REQ;
          end
        end
      end
      SEND_SUM: begin
        if (tx_data_ready) state_d = FIN;
      end
      FIN: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_VRAM_READER_CHECKSUM_EN
    // Checksum byte includes the data byte consumed on the entering edge.
    if (state_d == SEND_SUM && state_q != SEND_SUM) tx_data_d = sum_d;
`endif
  end

  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0000;
      cnt_q     <= 16'h0000;
      word_q    <= 16'h0000;
      tx_data_q <= 8'h00;
      abort_q   <= 1'b0;
      lat_q     <= '0;
`ifdef UART_VRAM_READER_CHECKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      tx_data_q <= tx_data_d;
      abort_q   <= abort_d;
      lat_q     <= lat_d;
`ifdef UART_VRAM_READER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign ram_re        = (state_q == RD_REQ);
  assign ram_addr      = addr_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = (state_q == SEND_LO) || (state_q == SEND_HI) || (state_q == SEND_SUM);

endmodule
